// File: rtl/fpga_ip_wb_pkg.sv
// rtl/fpga_ip_wb_pkg.sv - shared state encodings, default read values and base addresses for the FPGA IP Wishbone fabric
package fpga_ip_wb_pkg;

  // Access state of the aperture decoder
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DFLT = 2'd2,
    ST_TOUT = 2'd3
  } wb_state_e;

  // Read data returned when nobody answers
  localparam logic [31:0] WB_DEFAULT_READ_VALUE = 32'hBADFABAC;
  // Reset value used by unimplemented registers inside the slaves
  localparam logic [31:0] FPGA_QL_DEF_REG_VALUE = 32'hFABDEFAC;

  // Standard slave base addresses (17-bit byte addresses)
  localparam logic [16:0] FPGA_WB_SLV0_BASE = 17'h01000;
  localparam logic [16:0] FPGA_WB_SLV1_BASE = 17'h02000;
  localparam logic [16:0] FPGA_WB_SLV2_BASE = 17'h03000;
  localparam logic [16:0] FPGA_WB_SLV3_BASE = 17'h05000;

endpackage

// File: rtl/fpga_ip_wb_watchdog.sv
// rtl/fpga_ip_wb_watchdog.sv - saturating 8-bit access watchdog with clear/enable and limit-reached flag
module fpga_ip_wb_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_limit
);

  localparam logic [8:0] LIMIT_W = 9'(LIMIT);

  logic [7:0] r_cnt;
  logic [8:0] w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // Count wait cycles, holding at 255 so a long stall never aliases to a small count
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // High in the wait cycle whose increment brings the count to the limit;
  // kept independent of i_en so the caller's next-state logic has no loop through it
  assign o_limit = (w_cnt_inc >= LIMIT_W);

endmodule

// File: rtl/fpga_ip_wb_aperture_decoder.sv
// rtl/fpga_ip_wb_aperture_decoder.sv - Wishbone aperture decoder/interconnect with access watchdog; FPGA_IP_WB_ERR_LOG_EN adds an error log
module fpga_ip_wb_aperture_decoder
  import fpga_ip_wb_pkg::*;
#(
  parameter int                              APERWIDTH          = 17,
  parameter int                              APERSIZE           = 10,
  parameter int                              NUM_SLV            = 4,
  parameter logic [NUM_SLV*APERWIDTH-1:0]    SLV_BASE           = {FPGA_WB_SLV3_BASE, FPGA_WB_SLV2_BASE,
                                                                   FPGA_WB_SLV1_BASE, FPGA_WB_SLV0_BASE},
  parameter logic [31:0]                     DEFAULT_READ_VALUE = WB_DEFAULT_READ_VALUE,
  parameter int                              TIMEOUT_CYCLES     = 15
) (
  input  logic                    WBs_CLK_i,
  input  logic                    WBs_RST_i,
  input  logic [APERWIDTH-1:0]    WBs_ADR_i,
  input  logic                    WBs_CYC_i,
  input  logic                    WBs_STB_i,
  output logic [31:0]             WBs_DAT_o,
  output logic                    WBs_ACK_o,
  output logic [NUM_SLV-1:0]      SLV_CYC_o,
  input  logic [32*NUM_SLV-1:0]   SLV_DAT_i,
  input  logic [NUM_SLV-1:0]      SLV_ACK_i,
`ifdef FPGA_IP_WB_ERR_LOG_EN
  output logic [APERWIDTH-1:0]    ERR_ADR_o,
  input  logic                    ERR_WE_i,
  output logic                    ERR_WE_o,
  output logic [7:0]              ERR_CNT_o,
  output logic                    ERR_IRQ_o,
  input  logic                    ERR_CLR_i,
`endif
  output logic                    TOUT_o
);

  localparam int TAGW = APERWIDTH - APERSIZE;

  wb_state_e            r_state;
  wb_state_e            w_state_nxt;
  logic [NUM_SLV-1:0]   w_hit_vec;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_found;
  logic                 w_hit;
  logic [31:0]          w_slv_dat;
  logic                 w_slv_ack;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic                 w_limit;
  logic                 w_term;
  logic                 w_tout;

  // Compare the address tag against every slave base
  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_hit_vec[i] = (WBs_ADR_i[APERWIDTH-1:APERSIZE] == SLV_BASE[i*APERWIDTH+APERSIZE +: TAGW]);
    end
  end

  // Overlapping apertures resolve to the lowest slave index
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_hit_vec[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_hit = |w_hit_vec;

  // Read data mux driven by the one-hot select
  always_comb begin
    w_slv_dat = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel[i]) begin
        w_slv_dat = SLV_DAT_i[i*32 +: 32];
      end
    end
  end

  // Only the selected slave may complete the access
  assign w_slv_ack = |(SLV_ACK_i & w_sel);

  fpga_ip_wb_watchdog #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk   (WBs_CLK_i),
    .i_rst   (WBs_RST_i),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_limit (w_limit)
  );

  // State register
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a slave ACK beats both abort and timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (WBs_CYC_i && WBs_STB_i) begin
          if (w_hit) begin
            w_state_nxt = ST_BUSY;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_DFLT;
          end
        end
      end
      ST_BUSY: begin
        if (w_slv_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (!WBs_CYC_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_limit) begin
            w_state_nxt = ST_TOUT;
          end
        end
      end
      ST_DFLT, ST_TOUT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are held quiet while reset is asserted so a reset mid-access never ACKs
  assign w_term    = (r_state == ST_DFLT) || (r_state == ST_TOUT);
  assign w_tout    = w_term && !WBs_RST_i;
  assign TOUT_o    = w_tout;
  assign WBs_ACK_o = !WBs_RST_i && (((r_state == ST_BUSY) && w_slv_ack) || w_term);
  assign SLV_CYC_o = (WBs_RST_i || w_term) ? '0 : (w_sel & {NUM_SLV{WBs_CYC_i}});
  assign WBs_DAT_o = (w_hit && !w_term) ? w_slv_dat : DEFAULT_READ_VALUE;

`ifdef FPGA_IP_WB_ERR_LOG_EN
  logic [APERWIDTH-1:0] r_err_adr;
  logic                 r_err_we;
  logic [7:0]           r_err_cnt;
  logic                 r_err_irq;

  // Record each termination; a termination in the clear cycle still counts
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_err_adr <= '0;
      r_err_we  <= 1'b0;
      r_err_cnt <= '0;
      r_err_irq <= 1'b0;
    end else if (w_tout) begin
      r_err_adr <= WBs_ADR_i;
      r_err_we  <= ERR_WE_i;
      r_err_irq <= 1'b1;
      if (ERR_CLR_i) begin
        r_err_cnt <= 8'd1;
      end else if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end else if (ERR_CLR_i) begin
      r_err_cnt <= '0;
      r_err_irq <= 1'b0;
    end
  end

  assign ERR_ADR_o = r_err_adr;
  assign ERR_WE_o  = r_err_we;
  assign ERR_CNT_o = r_err_cnt;
  assign ERR_IRQ_o = r_err_irq;
`else
  // Offset bits inside an aperture are decoded by the slaves, not here
  logic w_unused_adr;
  assign w_unused_adr = ^WBs_ADR_i[APERSIZE-1:0];
`endif

endmodule
